// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register.
// Takes the memory-stage result into the writeback stage. For a load it
// picks the byte/half/word lane of the read word and extends it; otherwise
// it passes the ALU result through. It also handles stall/flush, carries a
// valid bit, flags misaligned loads and counts retired instructions.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   stall, flush      hold all WB outputs / insert a bubble (flush wins)
//   valid_MEM         MEM-stage instruction valid
//   opcode_wb, rd     opcode and destination register (JAL -> LINK_REG)
//   qram, d2          raw memory read word, ALU result
//   control_MEM       control word; bit LOAD_BIT selects load data
//   mem_size          00 word, 01 half, 10 byte, 11 treated as word
//   mem_unsigned      1 = zero-extend load, 0 = sign-extend
//   addr_lo           effective address bits [1:0]
//   d2_WB, save_mem   writeback data (identical copies)
//   rd_WB, control_WB, valid_WB, misalign_WB   registered WB fields
//   retire_count      number of valid instructions captured (wraps)
module mem_wb_stage_reg #(
    parameter int unsigned     DATA_W   = 32,
    parameter int unsigned     CTRL_W   = 8,
    parameter int unsigned     LOAD_BIT = 7,
    parameter int unsigned     RD_W     = 5,
    parameter int unsigned     OP_W     = 6,
    parameter logic [OP_W-1:0] JAL_OP   = OP_W'(3),
    parameter logic [RD_W-1:0] LINK_REG = '1,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     valid_MEM,
    input  logic [OP_W-1:0]          opcode_wb,
    input  logic [DATA_W-1:0]        qram,
    input  logic signed [DATA_W-1:0] d2,
    input  logic [RD_W-1:0]          rd,
    input  logic [CTRL_W-1:0]        control_MEM,
    input  logic [1:0]               mem_size,
    input  logic                     mem_unsigned,
    input  logic [1:0]               addr_lo,
    output logic signed [DATA_W-1:0] d2_WB,
    output logic signed [DATA_W-1:0] save_mem,
    output logic [RD_W-1:0]          rd_WB,
    output logic [CTRL_W-1:0]        control_WB,
    output logic                     valid_WB,
    output logic                     misalign_WB,
    output logic [CNT_W-1:0]         retire_count
);

    localparam logic [1:0] SizeWord = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeByte = 2'b10;

    logic                     is_load;
    logic                     misalign;
    logic [7:0]               byte_lane;
    logic [15:0]              half_lane;
    logic [DATA_W-1:0]        load_data;
    logic signed [DATA_W-1:0] wb_data;
    logic [RD_W-1:0]          wb_rd;
    logic [CTRL_W-1:0]        wb_ctrl;

    logic signed [DATA_W-1:0] data_q;
    logic [RD_W-1:0]          rd_q;
    logic [CTRL_W-1:0]        ctrl_q;
    logic                     valid_q;
    logic                     misalign_q;
    logic [CNT_W-1:0]         count_q;

    always_comb begin
        is_load   = control_MEM[LOAD_BIT];
        byte_lane = qram[{addr_lo, 3'b000} +: 8];
        // Half lane comes from addr_lo[1] only, so it never wraps the word.
        half_lane = addr_lo[1] ? qram[31:16] : qram[15:0];

        // Fill the whole width with the extension bit first, then overlay
        // the extracted lane; this also covers DATA_W == 32 for words.
        load_data = '0;
        unique case (mem_size)
            SizeByte: begin
                load_data      = {DATA_W{~mem_unsigned & byte_lane[7]}};
                load_data[7:0] = byte_lane;
            end
            SizeHalf: begin
                load_data       = {DATA_W{~mem_unsigned & half_lane[15]}};
                load_data[15:0] = half_lane;
            end
            default: begin
                load_data       = {DATA_W{~mem_unsigned & qram[31]}};
                load_data[31:0] = qram[31:0];
            end
        endcase

        misalign = 1'b0;
        if (is_load) begin
            if (mem_size == SizeHalf) begin
                misalign = addr_lo[0];
            end else if (mem_size != SizeByte) begin
                misalign = (addr_lo != 2'b00);
            end
        end

        wb_data = is_load ? load_data : d2;
        wb_rd   = (opcode_wb == JAL_OP) ? LINK_REG : rd;
        // Misaligned or invalid instructions must not write the register file.
        wb_ctrl = (valid_MEM && !misalign) ? control_MEM : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q     <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else if (flush) begin
            data_q     <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (!stall) begin
            data_q     <= wb_data;
            rd_q       <= wb_rd;
            ctrl_q     <= wb_ctrl;
            valid_q    <= valid_MEM;
            misalign_q <= valid_MEM && misalign;
            if (valid_MEM) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign d2_WB        = data_q;
    assign save_mem     = data_q;
    assign rd_WB        = rd_q;
    assign control_WB   = ctrl_q;
    assign valid_WB     = valid_q;
    assign misalign_WB  = misalign_q;
    assign retire_count = count_q;

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
module tb_mem_wb_stage_reg;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               stall, flush, valid_MEM, mem_unsigned;
    logic [5:0]         opcode_wb;
    logic [31:0]        qram;
    logic signed [31:0] d2;
    logic [4:0]         rd;
    logic [7:0]         control_MEM;
    logic [1:0]         mem_size, addr_lo;

    logic signed [31:0] d2_WB, save_mem, d2_WB4, save_mem4;
    logic [4:0]         rd_WB, rd_WB4;
    logic [7:0]         control_WB, control_WB4;
    logic               valid_WB, misalign_WB, valid_WB4, misalign_WB4;
    logic [31:0]        retire_count;
    logic [3:0]         retire_count4;

    // Reference model state (expected WB outputs).
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic [7:0]  e_ctrl;
    logic        e_valid, e_mis;
    logic [31:0] e_cnt;
    logic [3:0]  e_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_wb_stage_reg dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valid_MEM(valid_MEM),
        .opcode_wb(opcode_wb), .qram(qram), .d2(d2), .rd(rd), .control_MEM(control_MEM),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr_lo(addr_lo),
        .d2_WB(d2_WB), .save_mem(save_mem), .rd_WB(rd_WB), .control_WB(control_WB),
        .valid_WB(valid_WB), .misalign_WB(misalign_WB), .retire_count(retire_count)
    );

    mem_wb_stage_reg #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush), .valid_MEM(valid_MEM),
        .opcode_wb(opcode_wb), .qram(qram), .d2(d2), .rd(rd), .control_MEM(control_MEM),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr_lo(addr_lo),
        .d2_WB(d2_WB4), .save_mem(save_mem4), .rd_WB(rd_WB4), .control_WB(control_WB4),
        .valid_WB(valid_WB4), .misalign_WB(misalign_WB4), .retire_count(retire_count4)
    );

    task automatic model_reset();
        e_data = 0; e_rd = 0; e_ctrl = 0; e_valid = 0; e_mis = 0; e_cnt = 0; e_cnt4 = 0;
    endtask

    // Expected effect of one rising edge, from the behavioural rules.
    task automatic model_edge();
        logic [31:0] v;
        logic        mis;
        if (flush) begin
            e_data = 0; e_rd = 0; e_ctrl = 0; e_valid = 0; e_mis = 0;
        end else if (!stall) begin
            mis = 1'b0;
            if (control_MEM[7]) begin
                if (mem_size == 2) begin
                    v = (qram >> (8 * addr_lo)) % 256;
                    if (!mem_unsigned && v >= 128) v = v - 256;
                end else if (mem_size == 1) begin
                    v = (qram >> (16 * (addr_lo / 2))) % 65536;
                    if (!mem_unsigned && v >= 32768) v = v - 65536;
                    mis = (addr_lo % 2 == 1);
                end else begin
                    v   = qram;
                    mis = (addr_lo != 0);
                end
            end else begin
                v = d2;
            end
            e_data  = v;
            e_rd    = (opcode_wb == 6'd3) ? 5'd31 : rd;
            e_valid = valid_MEM;
            e_mis   = valid_MEM && mis;
            e_ctrl  = (valid_MEM && !mis) ? control_MEM : 8'h00;
            if (valid_MEM) begin
                e_cnt  = e_cnt + 1;
                e_cnt4 = 4'((e_cnt4 + 1) % 16);
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_random();
        valid_MEM    = 1'($urandom);
        opcode_wb    = 6'($urandom);
        qram         = $urandom;
        d2           = $urandom;
        rd           = 5'($urandom);
        control_MEM  = 8'($urandom);
        mem_size     = 2'($urandom);
        mem_unsigned = 1'($urandom);
        addr_lo      = 2'($urandom);
    endtask

    task automatic drive_alu(input logic [31:0] data, input logic [7:0] ctrl);
        stall = 0; flush = 0; valid_MEM = 1; opcode_wb = 6'h20; qram = 32'h0;
        d2 = data; rd = 5'd7; control_MEM = ctrl; mem_size = 0; mem_unsigned = 0; addr_lo = 0;
    endtask

    task automatic drive_load(input logic [1:0] sz, input logic uns, input logic [1:0] a);
        stall = 0; flush = 0; valid_MEM = 1; opcode_wb = 6'h23; qram = 32'h80FF7F01;
        d2 = 32'h0BADF00D; rd = 5'd9; control_MEM = 8'h80; mem_size = sz;
        mem_unsigned = uns; addr_lo = a;
    endtask

    task automatic test_reset();
        reset = 0; stall = 0; flush = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive_random();
            @(posedge clock);
            #1;
            n_checks++;
            if ({d2_WB, save_mem, rd_WB, control_WB, valid_WB, misalign_WB, retire_count} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: got d2=%h save=%h rd=%h ctrl=%h v=%b m=%b cnt=%h, need all 0",
                         d2_WB, save_mem, rd_WB, control_WB, valid_WB, misalign_WB, retire_count);
            end
            n_checks++;
            if ({d2_WB4, rd_WB4, control_WB4, valid_WB4, retire_count4} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold4: got d2=%h cnt=%h, need 0", d2_WB4, retire_count4);
            end
        end
        #3 reset = 1;
        drive_alu(32'h12345678, 8'h01);
        cycle();
        n_checks++;
        if (d2_WB !== 32'h12345678 || save_mem !== 32'h12345678 || retire_count !== 32'd1) begin
            n_fail++;
            $display("FAIL first_capture: got d2=%h save=%h cnt=%0d, need 12345678/12345678/1",
                     d2_WB, save_mem, retire_count);
        end
    endtask

    task automatic test_loads();
        logic [31:0] exp_v [4];
        logic [1:0]  sz    [4];
        logic        un    [4];
        logic [1:0]  ad    [4];
        exp_v = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h80FF7F01};
        sz    = '{2'b10, 2'b10, 2'b01, 2'b00};
        un    = '{1'b0, 1'b1, 1'b0, 1'b0};
        ad    = '{2'd3, 2'd3, 2'd2, 2'd0};
        for (int i = 0; i < 4; i++) begin
            drive_load(sz[i], un[i], ad[i]);
            cycle();
            n_checks++;
            if (d2_WB !== exp_v[i] || save_mem !== exp_v[i] || control_WB !== 8'h80 ||
                misalign_WB !== 1'b0 || rd_WB !== 5'd9) begin
                n_fail++;
                $display("FAIL load_%0d: got d2=%h save=%h ctrl=%h mis=%b rd=%0d, need %h/%h/80/0/9",
                         i, d2_WB, save_mem, control_WB, misalign_WB, rd_WB, exp_v[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [1:0] sz [2];
        sz = '{2'b00, 2'b01};
        for (int i = 0; i < 2; i++) begin
            drive_load(sz[i], 1'b0, 2'd1);
            cycle();
            n_checks++;
            if (misalign_WB !== 1'b1 || control_WB !== 8'h00 || valid_WB !== 1'b1 ||
                d2_WB !== e_data) begin
                n_fail++;
                $display("FAIL misalign_%0d: got mis=%b ctrl=%h v=%b d2=%h, need 1/00/1/%h",
                         i, misalign_WB, control_WB, valid_WB, d2_WB, e_data);
            end
        end
        // Same bad address on a non-load must not flag.
        drive_alu(32'hCAFE0001, 8'h01);
        addr_lo = 2'd1;
        cycle();
        n_checks++;
        if (misalign_WB !== 1'b0 || control_WB !== 8'h01) begin
            n_fail++;
            $display("FAIL misalign_nonload: got mis=%b ctrl=%h, need 0/01", misalign_WB, control_WB);
        end
    endtask

    task automatic test_jal();
        drive_alu(32'h00001000, 8'h01);
        opcode_wb = 6'b000011; rd = 5'd5;
        cycle();
        n_checks++;
        if (rd_WB !== 5'd31) begin
            n_fail++;
            $display("FAIL jal_link: got rd=%0d, need 31", rd_WB);
        end
        for (int i = 0; i < 4; i++) begin
            do opcode_wb = 6'($urandom); while (opcode_wb == 6'b000011);
            rd = 5'd5;
            cycle();
            n_checks++;
            if (rd_WB !== 5'd5) begin
                n_fail++;
                $display("FAIL jal_other op=%h: got rd=%0d, need 5", opcode_wb, rd_WB);
            end
        end
    endtask

    task automatic test_stall_flush();
        drive_alu(32'h55AA55AA, 8'h41);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive_random();
            stall = 1; flush = 0;
            cycle();
            n_checks++;
            if (d2_WB !== 32'h55AA55AA || control_WB !== 8'h41 || retire_count !== e_cnt ||
                rd_WB !== e_rd || valid_WB !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_%0d: got d2=%h ctrl=%h cnt=%0d rd=%0d v=%b, need 55aa55aa/41/%0d/%0d/1",
                         i, d2_WB, control_WB, retire_count, rd_WB, valid_WB, e_cnt, e_rd);
            end
        end
        drive_random();
        valid_MEM = 1;
        stall = 1; flush = 1;
        cycle();
        n_checks++;
        if (valid_WB !== 1'b0 || control_WB !== 8'h00 || d2_WB !== 32'h0 || save_mem !== 32'h0 ||
            rd_WB !== 5'd0 || misalign_WB !== 1'b0 || retire_count !== e_cnt) begin
            n_fail++;
            $display("FAIL stall_flush: got v=%b ctrl=%h d2=%h rd=%0d cnt=%0d, need 0/00/0/0/%0d",
                     valid_WB, control_WB, d2_WB, rd_WB, retire_count, e_cnt);
        end
    endtask

    task automatic test_async_reset();
        drive_alu(32'h0F0F0F0F, 8'h03);
        cycle();
        stall = 1;
        #2 reset = 0;
        #1;
        model_reset();
        n_checks++;
        if ({d2_WB, save_mem, rd_WB, control_WB, valid_WB, misalign_WB, retire_count} !== '0 ||
            retire_count4 !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: got d2=%h ctrl=%h v=%b cnt=%0d cnt4=%0d, need all 0",
                     d2_WB, control_WB, valid_WB, retire_count, retire_count4);
        end
        #1 reset = 1;
        stall = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_counter_wrap();
        reset = 0;
        #1;
        model_reset();
        reset = 1;
        for (int i = 0; i < 17; i++) begin
            drive_alu(i, 8'h01);
            cycle();
        end
        n_checks++;
        if (retire_count4 !== 4'd1 || retire_count !== 32'd17) begin
            n_fail++;
            $display("FAIL counter_wrap: got cnt4=%0d cnt=%0d, need 1/17", retire_count4, retire_count);
        end
        for (int i = 0; i < 3; i++) begin
            drive_alu(32'hDEAD0000 + i, 8'h01);
            valid_MEM = 0;
            cycle();
            n_checks++;
            if (retire_count4 !== 4'd1 || retire_count !== 32'd17 || control_WB !== 8'h00 ||
                d2_WB !== e_data) begin
                n_fail++;
                $display("FAIL invalid_capture_%0d: got cnt4=%0d cnt=%0d ctrl=%h d2=%h, need 1/17/00/%h",
                         i, retire_count4, retire_count, control_WB, d2_WB, e_data);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive_random();
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            cycle();
            n_checks++;
            if ({d2_WB, save_mem, rd_WB, control_WB, valid_WB, misalign_WB, retire_count,
                 retire_count4} !== {e_data, e_data, e_rd, e_ctrl, e_valid, e_mis, e_cnt, e_cnt4}) begin
                n_fail++;
                $display("FAIL random_%0d: got d2=%h save=%h rd=%0d ctrl=%h v=%b m=%b cnt=%0d cnt4=%0d, need d2=%h rd=%0d ctrl=%h v=%b m=%b cnt=%0d cnt4=%0d",
                         i, d2_WB, save_mem, rd_WB, control_WB, valid_WB, misalign_WB, retire_count,
                         retire_count4, e_data, e_rd, e_ctrl, e_valid, e_mis, e_cnt, e_cnt4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_misaligned();
        test_jal();
        test_stall_flush();
        test_async_reset();
        test_counter_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
